operand_feeder: RTL

OPERAND_FEEDER -- requirements
Module: operand_feeder

---
 rtl/mm_pkg.sv | 13 +
 rtl/feeder_fifo.sv | 48 ++++
 rtl/operand_feeder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared types and defaults for the matrix-multiply operand feeder slice.
package mm_pkg;

  localparam int unsigned MM_D_WIDTH     = 64;
  localparam int unsigned MM_N_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous FIFO buffering host operand beats; 2^FIFO_AW entries, show-ahead read port.
module feeder_fifo #(
  parameter int unsigned D_WIDTH = 64,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic               rd_en,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               empty
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW:0]   wr_ptr;
  logic [FIFO_AW:0]   rd_ptr;
  logic               full;
  logic               wr_fire;
  logic               rd_fire;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign wr_ready = !full;
  assign wr_fire  = wr_valid && !full;
  assign rd_fire  = rd_en && !empty;
  assign rd_data  = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
      if (rd_fire) rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
    end
  end

endmodule

// File: rtl/operand_feeder.sv
// Streams N k-steps of A and B operands from host FIFOs into the PE chain head.
// Optional FEEDER_STALL_CNT_EN adds stall_cnt_out (RUN cycles starved of data).
module operand_feeder
  import mm_pkg::*;
#(
  parameter int unsigned D_WIDTH     = MM_D_WIDTH,
  parameter int unsigned A_NUM_WIDTH = 3,
  parameter int unsigned B_NUM_WIDTH = 3,
  parameter int unsigned N_MAX_WIDTH = MM_N_MAX_WIDTH,
  parameter int unsigned FIFO_AW     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [D_WIDTH-1:0]     host_a_data_in,
  input  logic                   host_a_valid_in,
  output logic                   host_a_ready_out,
  input  logic [D_WIDTH-1:0]     host_b_data_in,
  input  logic                   host_b_valid_in,
  output logic                   host_b_ready_out,
  input  logic                   start_in,
  input  logic [N_MAX_WIDTH-1:0] N_in,
  output logic [D_WIDTH-1:0]     A_out,
  output logic                   A_valid_out,
  output logic [D_WIDTH-1:0]     B_out,
  output logic                   B_valid_out,
  output logic                   busy_out,
  output logic                   done_out
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [N_MAX_WIDTH-1:0] stall_cnt_out
`endif
);

  feeder_state_t state, next_state;

  logic [N_MAX_WIDTH-1:0] n_lat;
  logic [A_NUM_WIDTH-1:0] a_elem;
  logic [B_NUM_WIDTH-1:0] b_elem;
  logic [N_MAX_WIDTH-1:0] a_k;
  logic [N_MAX_WIDTH-1:0] b_k;
  logic [D_WIDTH-1:0]     a_head;
  logic [D_WIDTH-1:0]     b_head;
  logic                   a_empty;
  logic                   b_empty;
  logic                   a_owe;
  logic                   b_owe;
  logic                   a_pop;
  logic                   b_pop;
  logic                   run_start;

  feeder_fifo #(.D_WIDTH(D_WIDTH), .FIFO_AW(FIFO_AW)) u_fifo_a (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (host_a_data_in),
    .wr_valid (host_a_valid_in),
    .wr_ready (host_a_ready_out),
    .rd_en    (a_pop),
    .rd_data  (a_head),
    .empty    (a_empty)
  );

  feeder_fifo #(.D_WIDTH(D_WIDTH), .FIFO_AW(FIFO_AW)) u_fifo_b (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (host_b_data_in),
    .wr_valid (host_b_valid_in),
    .wr_ready (host_b_ready_out),
    .rd_en    (b_pop),
    .rd_data  (b_head),
    .empty    (b_empty)
  );

  // A channel still owes data while its completed k-steps are below N.
  assign a_owe     = (a_k < n_lat);
  assign b_owe     = (b_k < n_lat);
  assign a_pop     = (state == ST_RUN) && a_owe && !a_empty;
  assign b_pop     = (state == ST_RUN) && b_owe && !b_empty;
  assign run_start = (state == ST_IDLE) && (next_state == ST_RUN);
  assign busy_out  = (state != ST_IDLE);

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: if (start_in) next_state = (N_in == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (!a_owe && !b_owe) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      n_lat <= '0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && start_in) n_lat <= N_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_elem <= '0;
      a_k    <= '0;
      b_elem <= '0;
      b_k    <= '0;
    end else if (run_start) begin
      a_elem <= '0;
      a_k    <= '0;
      b_elem <= '0;
      b_k    <= '0;
    end else begin
      if (a_pop) begin
        a_elem <= a_elem + A_NUM_WIDTH'(1);
        if (a_elem == '1) a_k <= a_k + N_MAX_WIDTH'(1);
      end
      if (b_pop) begin
        b_elem <= b_elem + B_NUM_WIDTH'(1);
        if (b_elem == '1) b_k <= b_k + N_MAX_WIDTH'(1);
      end
    end
  end

  // done_out is a registered copy of the DONE state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      A_out       <= '0;
      A_valid_out <= 1'b0;
      B_out       <= '0;
      B_valid_out <= 1'b0;
      done_out    <= 1'b0;
    end else begin
      A_valid_out <= a_pop;
      B_valid_out <= b_pop;
      if (a_pop) A_out <= a_head;
      if (b_pop) B_out <= b_head;
      done_out <= (state == ST_DONE);
    end
  end

`ifdef FEEDER_STALL_CNT_EN
  logic stall;

  assign stall = (state == ST_RUN) && ((a_owe && a_empty) || (b_owe && b_empty));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_out <= '0;
    end else if (run_start) begin
      stall_cnt_out <= '0;
    end else if (stall && (stall_cnt_out != '1)) begin
      stall_cnt_out <= stall_cnt_out + N_MAX_WIDTH'(1);
    end
  end
`endif

endmodule
